// File: rtl/address_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : address_sequencer_pkg
// Purpose : Shared definitions for the address sequencer: FSM state encoding
//           and the default address width.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package address_sequencer_pkg;

   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

endpackage : address_sequencer_pkg
`default_nettype wire

// File: rtl/address_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : address_sequencer
// Purpose : Produces the next-address value for a downstream address
//           register. Walks from a latched start address to a latched end
//           address (wrapping modulo 2^ADDR_W), one step per step_tick_i,
//           with pause, forced jump and end-of-sequence done pulse.
// Config  : ADDR_SEQ_LOOP_EN defined   -> the end step reloads the start
//                                         address and keeps running.
//           ADDR_SEQ_LOOP_EN undefined -> the end step holds and goes to DONE.
// Ports   : clk           system clock, rising edge
//           reset         asynchronous active-high reset
//           start_i       one-cycle sequence start request
//           pause_i       level, holds the address while high
//           step_tick_i   advance enable, one step per high cycle
//           start_addr_i  first address (sampled on accepted start)
//           end_addr_i    last address  (sampled on accepted start)
//           jump_en_i     one-cycle forced load request
//           jump_addr_i   forced load target
//           cur_addr_i    current address fed back from downstream register
//           next_value_o  next address, combinational
//           busy_o        high in RUN or PAUSE
//           done_o        one-cycle pulse when the end address is stepped past
// Revision: 1.0 - initial release
// ============================================================================
module address_sequencer
   import address_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic              pause_i,
   input  logic              step_tick_i,
   input  logic [ADDR_W-1:0] start_addr_i,
   input  logic [ADDR_W-1:0] end_addr_i,
   input  logic              jump_en_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic [ADDR_W-1:0] cur_addr_i,
   output logic [ADDR_W-1:0] next_value_o,
   output logic              busy_o,
   output logic              done_o
);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic [ADDR_W-1:0] end_addr_q, end_addr_d;
   logic [ADDR_W-1:0] w_incr;
   logic              w_at_end;

   // Natural overflow of the adder gives the modulo-2^ADDR_W wrap.
   assign w_incr   = cur_addr_i + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign w_at_end = (cur_addr_i == end_addr_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         start_addr_q <= '0;
         end_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         start_addr_q <= start_addr_d;
         end_addr_q   <= end_addr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      start_addr_d = start_addr_q;
      end_addr_d   = end_addr_q;
      next_value_o = cur_addr_i;
      done_o       = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               start_addr_d = start_addr_i;
               end_addr_d   = end_addr_i;
               next_value_o = start_addr_i;
               state_d      = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Jump beats pause beats step; a jump leaves the state alone.
            if (jump_en_i) begin
               next_value_o = jump_addr_i;
            end else if (pause_i) begin
               state_d = ST_PAUSE;
            end else if (step_tick_i) begin
               if (!w_at_end) begin
                  next_value_o = w_incr;
               end else begin
                  done_o = 1'b1;
`ifdef ADDR_SEQ_LOOP_EN
                  next_value_o = start_addr_q;
`else
                  state_d = ST_DONE;
`endif
               end
            end
         end
         ST_PAUSE: begin
            if (jump_en_i) begin
               next_value_o = jump_addr_i;
            end
            // The return cycle never steps; stepping resumes next cycle.
            if (!pause_i) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // While reset is asserted the downstream register must simply hold,
      // even if start is presented in the (forced) IDLE state.
      if (reset) begin
         next_value_o = cur_addr_i;
         done_o       = 1'b0;
      end
   end

   assign busy_o = !reset && ((state_q == ST_RUN) || (state_q == ST_PAUSE));

`ifndef ADDR_SEQ_LOOP_EN
   // The latched start address only matters when looping is enabled.
   logic w_unused_start;
   assign w_unused_start = ^start_addr_q;
`endif

endmodule : address_sequencer
`default_nettype wire

// File: tb/tb_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_address_sequencer
// Purpose : Self-checking bench for address_sequencer. Models the downstream
//           address register (cur_addr loads next_value every rising edge),
//           applies a table of per-cycle vectors with hand-computed expected
//           outputs, then runs hand-written asynchronous-reset sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_address_sequencer;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          pause = 1'b0;
   logic          step_tick = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic          jump_en = 1'b0;
   logic [AW-1:0] jump_addr = '0;
   logic [AW-1:0] cur_addr = '0;
   logic [AW-1:0] next_value;
   logic          busy;
   logic          done;

   int tests_run = 0;
   int tests_failed = 0;

   address_sequencer #(.ADDR_W(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start),
      .pause_i      (pause),
      .step_tick_i  (step_tick),
      .start_addr_i (start_addr),
      .end_addr_i   (end_addr),
      .jump_en_i    (jump_en),
      .jump_addr_i  (jump_addr),
      .cur_addr_i   (cur_addr),
      .next_value_o (next_value),
      .busy_o       (busy),
      .done_o       (done)
   );

   always #5 clk = ~clk;

   // Downstream address register (no reset: holds because next_value = cur).
   always @(posedge clk) cur_addr <= next_value;

   typedef struct {
      logic          rst;
      logic          start;
      logic          pause;
      logic          step;
      logic          jmp;
      logic [AW-1:0] jaddr;
      logic [AW-1:0] sa;
      logic [AW-1:0] ea;
      logic [AW-1:0] exp_next;
      logic          exp_busy;
      logic          exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic s, input logic p, input logic t,
                      input logic j, input logic [AW-1:0] ja, input logic [AW-1:0] sa,
                      input logic [AW-1:0] ea, input logic [AW-1:0] en,
                      input logic eb, input logic ed);
      vec_t v;
      v.rst = r; v.start = s; v.pause = p; v.step = t; v.jmp = j;
      v.jaddr = ja; v.sa = sa; v.ea = ea;
      v.exp_next = en; v.exp_busy = eb; v.exp_done = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [AW-1:0] act,
                        input logic [AW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   initial begin
      // rst start pause step jmp jaddr sa ea | next busy done
      // Reset state
      add(1,0,0,0,0,  0,  0,  0,    0,0,0);                 // 0
      // Basic run 3..6
      add(0,1,0,1,0,  0,  3,  6,    3,0,0);                 // 1
      add(0,0,0,1,0,  0,  0,  0,    4,1,0);                 // 2
      add(0,0,0,1,0,  0,  0,  0,    5,1,0);                 // 3
      add(0,0,0,1,0,  0,  0,  0,    6,1,0);                 // 4
`ifdef ADDR_SEQ_LOOP_EN
      add(0,0,0,1,0,  0,  0,  0,    3,1,1);                 // 5 end step, loop
      add(0,0,0,0,0,  0,  0,  0,    3,1,0);                 // 6
      add(1,0,0,1,0,  0,  0,  0,    3,0,0);                 // 7 reset
      add(0,0,0,1,1, 40,  0,  0,    3,0,0);                 // 8 jump in IDLE
`else
      add(0,0,0,1,0,  0,  0,  0,    6,1,1);                 // 5 end step
      add(0,0,0,0,0,  0,  0,  0,    6,0,0);                 // 6 DONE
      add(1,0,0,1,0,  0,  0,  0,    6,0,0);                 // 7 reset
      add(0,0,0,1,1, 40,  0,  0,    6,0,0);                 // 8 jump in IDLE
`endif
      // Wrap through zero: 254 -> 1
      add(0,1,0,1,0,  0,254,  1,  254,0,0);                 // 9
      add(0,0,0,1,0,  0,  0,  0,  255,1,0);                 // 10
      add(0,0,0,1,0,  0,  0,  0,    0,1,0);                 // 11
      add(0,0,0,1,0,  0,  0,  0,    1,1,0);                 // 12
`ifdef ADDR_SEQ_LOOP_EN
      add(0,0,0,1,0,  0,  0,  0,  254,1,1);                 // 13 lap 1 end
      add(0,0,0,1,0,  0,  0,  0,  255,1,0);                 // 14
      add(0,0,0,1,0,  0,  0,  0,    0,1,0);                 // 15
      add(0,0,0,1,0,  0,  0,  0,    1,1,0);                 // 16
      add(0,0,0,1,0,  0,  0,  0,  254,1,1);                 // 17 lap 2 end
      add(1,0,0,1,0,  0,  0,  0,  254,0,0);                 // 18 reset
`else
      add(0,0,0,1,0,  0,  0,  0,    1,1,1);                 // 13 end step
      add(0,0,0,1,0,  0,  0,  0,    1,0,0);                 // 14 DONE
      add(0,0,0,1,0,  0,  0,  0,    1,0,0);                 // 15 IDLE
      add(0,0,0,1,0,  0,  0,  0,    1,0,0);                 // 16
      add(0,0,0,1,0,  0,  0,  0,    1,0,0);                 // 17
      add(1,0,0,1,0,  0,  0,  0,    1,0,0);                 // 18 reset
`endif
      // Pause at 10 for five cycles with step_tick high
      add(0,1,0,1,0,  0, 10, 30,   10,0,0);                 // 19
      add(0,0,1,1,0,  0,  0,  0,   10,1,0);                 // 20
      add(0,0,1,1,0,  0,  0,  0,   10,1,0);                 // 21
      add(0,0,1,1,0,  0,  0,  0,   10,1,0);                 // 22
      add(0,0,1,1,0,  0,  0,  0,   10,1,0);                 // 23
      add(0,0,1,1,0,  0,  0,  0,   10,1,0);                 // 24
      add(0,0,0,1,0,  0,  0,  0,   10,1,0);                 // 25 return, no step
      add(0,0,0,1,0,  0,  0,  0,   11,1,0);                 // 26
      // Start ignored while running, bounds kept
      add(0,1,0,0,0,  0,100,200,   11,1,0);                 // 27
      // Jumps: to 20, then jump+step to 40 (jump wins)
      add(0,0,0,0,1, 20,  0,  0,   20,1,0);                 // 28
      add(0,0,0,1,1, 40,  0,  0,   40,1,0);                 // 29
      add(0,0,0,1,0,  0,  0,  0,   41,1,0);                 // 30
      add(0,0,0,0,1, 30,  0,  0,   30,1,0);                 // 31
`ifdef ADDR_SEQ_LOOP_EN
      add(0,0,0,1,0,  0,  0,  0,   10,1,1);                 // 32 end, reload
      add(0,1,0,1,0,  0,  5,  9,   11,1,0);                 // 33 start ignored
      add(0,0,0,0,0,  0,  0,  0,   11,1,0);                 // 34
`else
      add(0,0,0,1,0,  0,  0,  0,   30,1,1);                 // 32 end (30, not 200)
      add(0,1,0,1,0,  0,  5,  9,    5,0,0);                 // 33 start in DONE
      add(0,0,0,0,0,  0,  0,  0,    5,1,0);                 // 34
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         reset      = vecs[i].rst;
         start      = vecs[i].start;
         pause      = vecs[i].pause;
         step_tick  = vecs[i].step;
         jump_en    = vecs[i].jmp;
         jump_addr  = vecs[i].jaddr;
         start_addr = vecs[i].sa;
         end_addr   = vecs[i].ea;
         #1;
         check("next_value", i, next_value, vecs[i].exp_next);
         check("busy", i, {7'd0, busy}, {7'd0, vecs[i].exp_busy});
         check("done", i, {7'd0, done}, {7'd0, vecs[i].exp_done});
      end

      // ---- Asynchronous reset mid-run at address 5 ----
      @(negedge clk);
      start = 1'b0; pause = 1'b0; step_tick = 1'b0;
      jump_en = 1'b1; jump_addr = 8'd5;
      @(negedge clk);
      jump_en = 1'b0; step_tick = 1'b1;
      #1;
      check("pre_reset_cur", 100, cur_addr, 8'd5);
      check("pre_reset_next", 101, next_value, 8'd6);
      check("pre_reset_busy", 102, {7'd0, busy}, 8'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_busy", 103, {7'd0, busy}, 8'd0);
      check("async_reset_done", 104, {7'd0, done}, 8'd0);
      check("async_reset_next", 105, next_value, 8'd5);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("post_reset_busy", 110 + k, {7'd0, busy}, 8'd0);
         check("post_reset_done", 110 + k, {7'd0, done}, 8'd0);
         check("post_reset_hold", 110 + k, next_value, 8'd5);
         @(negedge clk);
      end
      // Start needed to resume; fresh bounds 7..8
      start = 1'b1; start_addr = 8'd7; end_addr = 8'd8;
      #1;
      check("restart_next", 120, next_value, 8'd7);
      @(negedge clk);
      start = 1'b0;
      #1;
      check("restart_cur", 121, cur_addr, 8'd7);
      check("restart_step", 122, next_value, 8'd8);
      @(negedge clk);
      #1;
      check("restart_end_done", 123, {7'd0, done}, 8'd1);
`ifdef ADDR_SEQ_LOOP_EN
      check("restart_end_next", 124, next_value, 8'd7);
`else
      check("restart_end_next", 124, next_value, 8'd8);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_address_sequencer
`default_nettype wire
